reg_access_ctrl: RTL and testbench

Sequencer that drives the 8 x 6-bit register file's single shared port.
- Accepts one decoded instruction request (rs1, rs2, rd).
- Reads the operands one per cycle through the shared address port and presents them to the ALU with a valid/ready handshake.
- Waits for the ALU result and writes it back to rd.
- Sits between the instruction decoder and the ALU; it is the only master of the register file's address, write-data and write-enable inputs.

---
 rtl/reg_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_access_ctrl : sequences operand reads, ALU handshake and write-back
//                   over the register file's single shared port.
// Revision 1.0
// ----------------------------------------------------------------------------
module reg_access_ctrl #(
   parameter int DATA_W  = 6,
   parameter int ADDR_W  = 3,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] rs1_i,
   input  logic [ADDR_W-1:0] rs2_i,
   input  logic [ADDR_W-1:0] rd_i,
   input  logic              use_rs2_i,
   input  logic              wb_en_i,
   output logic              op_valid_o,
   input  logic              op_ready_i,
   output logic [DATA_W-1:0] op_a_o,
   output logic [DATA_W-1:0] op_b_o,
   input  logic              res_valid_i,
   input  logic [DATA_W-1:0] res_data_i,
   output logic              res_ready_o,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic              reg_we_o,
   input  logic [DATA_W-1:0] reg_rdata_i,
   output logic              err_o,
   output logic [7:0]        wb_count_o
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      READ_A   = 3'd1,
      READ_B   = 3'd2,
      ISSUE    = 3'd3,
      WAIT_RES = 3'd4,
      WRITE    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic              use_rs2_q, use_rs2_d, wb_en_q, wb_en_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, wdata_q, wdata_d;
   logic [7:0]        wb_count_q, wb_count_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              err_q, err_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         use_rs2_q  <= 1'b0;
         wb_en_q    <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         wdata_q    <= '0;
         wb_count_q <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         use_rs2_q  <= use_rs2_d;
         wb_en_q    <= wb_en_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         wdata_q    <= wdata_d;
         wb_count_q <= wb_count_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      use_rs2_d   = use_rs2_q;
      wb_en_d     = wb_en_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      wdata_d     = wdata_q;
      wb_count_d  = wb_count_q;
      tmo_d       = tmo_q;
      err_d       = 1'b0;
      req_ready_o = 1'b0;
      op_valid_o  = 1'b0;
      res_ready_o = 1'b0;
      reg_we_o    = 1'b0;
      reg_addr_o  = '0;

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               rs1_d     = rs1_i;
               rs2_d     = rs2_i;
               rd_d      = rd_i;
               use_rs2_d = use_rs2_i;
               wb_en_d   = wb_en_i;
               state_d   = READ_A;
            end
         end
         READ_A: begin
            reg_addr_o = rs1_q;
            op_a_d     = (rs1_q == '0) ? '0 : reg_rdata_i;
            if (use_rs2_q) begin
               state_d = READ_B;
            end else begin
               op_b_d  = '0;
               state_d = ISSUE;
            end
         end
         READ_B: begin
            reg_addr_o = rs2_q;
            op_b_d     = (rs2_q == '0) ? '0 : reg_rdata_i;
            state_d    = ISSUE;
         end
         ISSUE: begin
            op_valid_o = 1'b1;
            if (op_ready_i) begin
               if (wb_en_q) begin
                  tmo_d   = '0;
                  state_d = WAIT_RES;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         WAIT_RES: begin
            res_ready_o = 1'b1;
            // A result on the final counted cycle still wins over the abort.
            if (res_valid_i) begin
               wdata_d = res_data_i;
               state_d = (rd_q == '0) ? IDLE : WRITE;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WRITE: begin
            reg_addr_o = rd_q;
            reg_we_o   = 1'b1;
            wb_count_d = wb_count_q + 8'd1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign op_a_o      = op_a_q;
   assign op_b_o      = op_b_q;
   assign reg_wdata_o = wdata_q;
   assign err_o       = err_q;
   assign wb_count_o  = wb_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reg_access_ctrl : directed vector bench with a behavioural register file.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_reg_access_ctrl;

   logic       clk, rst_n;
   logic       req_valid, req_ready;
   logic [2:0] rs1, rs2, rd;
   logic       use_rs2, wb_en;
   logic       op_valid, op_ready;
   logic [5:0] op_a, op_b;
   logic       res_valid, res_ready;
   logic [5:0] res_data;
   logic [2:0] reg_addr;
   logic [5:0] reg_wdata, reg_rdata;
   logic       reg_we, err;
   logic [7:0] wb_count;

   int n_checks = 0;
   int n_err    = 0;

   reg_access_ctrl #(.DATA_W(6), .ADDR_W(3), .TIMEOUT(15)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .rd_i        (rd),
      .use_rs2_i   (use_rs2),
      .wb_en_i     (wb_en),
      .op_valid_o  (op_valid),
      .op_ready_i  (op_ready),
      .op_a_o      (op_a),
      .op_b_o      (op_b),
      .res_valid_i (res_valid),
      .res_data_i  (res_data),
      .res_ready_o (res_ready),
      .reg_addr_o  (reg_addr),
      .reg_wdata_o (reg_wdata),
      .reg_we_o    (reg_we),
      .reg_rdata_i (reg_rdata),
      .err_o       (err),
      .wb_count_o  (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model; x0 deliberately reads back nonzero.
   localparam logic [5:0] RF_INIT [8] = '{6'h3F, 6'h01, 6'h00, 6'h15,
                                          6'h0C, 6'h2A, 6'h33, 6'h07};
   logic [5:0] rf [8];
   logic       tb_load;
   assign reg_rdata = rf[reg_addr];
   always @(negedge clk) begin
      if (tb_load) begin
         for (int i = 0; i < 8; i++) rf[i] <= RF_INIT[i];
      end else if (reg_we) begin
         rf[reg_addr] <= reg_wdata;
      end
   end

   typedef struct {
      logic [2:0] rs1, rs2, rd;
      logic       use_rs2, wb_en;
      logic [5:0] res;
      int         stall;
      logic [5:0] exp_a, exp_b;
      logic       exp_we;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v, input bit c);
      if (c) chk("req_ready_idle", 32'(req_ready), 1);
      rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
      use_rs2 = v.use_rs2; wb_en = v.wb_en; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      if (c) begin
         chk("read_a_addr", 32'(reg_addr), 32'(v.rs1));
         chk("read_a_no_valid", 32'(op_valid), 0);
         chk("read_a_req_ready", 32'(req_ready), 0);
      end
      if (v.use_rs2) begin
         step();
         if (c) begin
            chk("read_b_addr", 32'(reg_addr), 32'(v.rs2));
            chk("read_b_no_valid", 32'(op_valid), 0);
         end
      end
      step();
      if (c) begin
         chk("op_valid", 32'(op_valid), 1);
         chk("op_a", 32'(op_a), 32'(v.exp_a));
         chk("op_b", 32'(op_b), 32'(v.exp_b));
         chk("issue_addr", 32'(reg_addr), 0);
      end
      op_ready = 1'b0;
      if (v.stall > 0) begin
         rs1 = ~v.rs1; rs2 = ~v.rs2; rd = ~v.rd; req_valid = 1'b1;
      end
      for (int s = 0; s < v.stall; s++) begin
         step();
         if (c) begin
            chk("stall_valid", 32'(op_valid), 1);
            chk("stall_op_a", 32'(op_a), 32'(v.exp_a));
            chk("stall_op_b", 32'(op_b), 32'(v.exp_b));
            chk("stall_req_ready", 32'(req_ready), 0);
         end
      end
      req_valid = 1'b0;
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      if (v.wb_en) begin
         if (c) chk("res_ready", 32'(res_ready), 1);
         res_valid = 1'b1; res_data = v.res;
         step();
         res_valid = 1'b0;
         if (v.exp_we) begin
            if (c) begin
               chk("write_we", 32'(reg_we), 1);
               chk("write_addr", 32'(reg_addr), 32'(v.rd));
               chk("write_data", 32'(reg_wdata), 32'(v.res));
            end
            step();
         end
      end
      if (c) begin
         chk("end_we_low", 32'(reg_we), 0);
         chk("end_req_ready", 32'(req_ready), 1);
         chk("end_wb_count", 32'(wb_count), 32'(v.exp_cnt));
         chk("end_err", 32'(err), 0);
         if (v.exp_we) chk("rf_written", 32'(rf[v.rd]), 32'(v.res));
      end
   endtask

   // Request with use_rs2=0 into rd=6, stepped up to the ISSUE handshake.
   task automatic to_wait_res();
      rs1 = 3'd3; rs2 = 3'd0; rd = 3'd6; use_rs2 = 1'b0; wb_en = 1'b1;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      chk("tmo_op_valid", 32'(op_valid), 1);
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      vec_t w;
      vecs[0] = '{3'd3, 3'd5, 3'd2, 1'b1, 1'b1, 6'h3F, 0, 6'h15, 6'h2A, 1'b1, 8'd1};
      vecs[1] = '{3'd0, 3'd5, 3'd4, 1'b0, 1'b0, 6'h00, 0, 6'h00, 6'h00, 1'b0, 8'd1};
      vecs[2] = '{3'd6, 3'd0, 3'd0, 1'b1, 1'b1, 6'h11, 0, 6'h33, 6'h00, 1'b0, 8'd1};
      vecs[3] = '{3'd2, 3'd7, 3'd7, 1'b1, 1'b1, 6'h05, 4, 6'h3F, 6'h07, 1'b1, 8'd2};
      vecs[4] = '{3'd7, 3'd1, 3'd1, 1'b0, 1'b1, 6'h2C, 0, 6'h05, 6'h00, 1'b1, 8'd3};
      vecs[5] = '{3'd1, 3'd1, 3'd5, 1'b1, 1'b1, 6'h00, 1, 6'h2C, 6'h2C, 1'b1, 8'd4};

      rst_n = 1'b1; tb_load = 1'b1;
      req_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; use_rs2 = 1'b0; wb_en = 1'b0;
      op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_op_valid", 32'(op_valid), 0);
      chk("rst_res_ready", 32'(res_ready), 0);
      chk("rst_reg_we", 32'(reg_we), 0);
      chk("rst_reg_addr", 32'(reg_addr), 0);
      chk("rst_op_a", 32'(op_a), 0);
      chk("rst_op_b", 32'(op_b), 0);
      chk("rst_wdata", 32'(reg_wdata), 0);
      chk("rst_wb_count", 32'(wb_count), 0);
      chk("rst_err", 32'(err), 0);
      step(); step();
      rst_n = 1'b1;
      tb_load = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b1);

      // Result never arrives: err exactly 15 cycles after the handshake.
      to_wait_res();
      k = 0;
      while (err !== 1'b1 && k < 30) begin
         step();
         k++;
      end
      chk("tmo_cycles", 32'(k), 15);
      chk("tmo_idle", 32'(req_ready), 1);
      chk("tmo_no_we", 32'(reg_we), 0);
      step();
      chk("tmo_err_pulse", 32'(err), 0);
      chk("tmo_wb_count", 32'(wb_count), 4);
      chk("tmo_rf_untouched", 32'(rf[6]), 32'h33);

      // Result on the last counted cycle is accepted.
      to_wait_res();
      repeat (14) step();
      chk("late_res_ready", 32'(res_ready), 1);
      chk("late_no_err", 32'(err), 0);
      res_valid = 1'b1; res_data = 6'h1A;
      step();
      res_valid = 1'b0;
      chk("late_we", 32'(reg_we), 1);
      chk("late_err", 32'(err), 0);
      step();
      chk("late_err_after", 32'(err), 0);
      chk("late_wb_count", 32'(wb_count), 5);
      chk("late_rf", 32'(rf[6]), 32'h1A);

      // Reset in the WRITE cycle discards the write.
      rs1 = 3'd3; rd = 3'd4; use_rs2 = 1'b0; wb_en = 1'b1; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      res_valid = 1'b1; res_data = 6'h2E;
      step();
      res_valid = 1'b0;
      chk("wr_rst_we_before", 32'(reg_we), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("wr_rst_we", 32'(reg_we), 0);
      chk("wr_rst_wb_count", 32'(wb_count), 0);
      chk("wr_rst_req_ready", 32'(req_ready), 1);
      chk("wr_rst_addr", 32'(reg_addr), 0);
      #4;
      chk("wr_rst_rf", 32'(rf[4]), 32'h0C);
      rst_n = 1'b1;
      step();
      chk("wr_rst_idle", 32'(req_ready), 1);

      // 256 writes wrap the counter.
      w = '{3'd0, 3'd0, 3'd1, 1'b0, 1'b1, 6'h00, 0, 6'h00, 6'h00, 1'b1, 8'd0};
      for (int i = 0; i < 255; i++) begin
         w.res = 6'(i);
         run_txn(w, 1'b0);
      end
      chk("wrap_255", 32'(wb_count), 255);
      w.res = 6'h21;
      run_txn(w, 1'b0);
      chk("wrap_0", 32'(wb_count), 0);
      chk("wrap_rf", 32'(rf[1]), 32'h21);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
